stream_demux4: RTL and testbench

Four-way routing demultiplexer with valid/ready handshakes: accepts one data beat per cycle tagged with a 2-bit key and delivers it to one of four output channels, each with a one-entry output register. It is the distribution counterpart to the keyed 4:1 selectors in the design. It sits between a single producer and four independent consumers, such as per-unit command queues and display or LED sinks.

---
 rtl/stream_demux4.sv | 102 ++++++++++
 tb/tb_stream_demux4.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/stream_demux4.sv
// stream_demux4: keyed 1:4 valid/ready demultiplexer with a one-entry register per channel.
// Optional per-channel delivery counters are enabled by defining STREAM_DEMUX4_CNT_EN.
module stream_demux4 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_key,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [3:0]            ch_en,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [4*DATA_W-1:0]   out_data,
    output logic                  drop_err
`ifdef STREAM_DEMUX4_CNT_EN
    ,
    output logic [4*CNT_W-1:0]    cnt_flat
`endif
);

    logic [3:0]        full;
    logic [DATA_W-1:0] d [4];
    logic              sel_en;
    logic              accept;
    logic [3:0]        load;
    logic [3:0]        drain;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("stream_demux4: CNT_W must be at least 1");
    end

    // A disabled destination swallows the beat, so it never backpressures the producer.
    always_comb begin
        sel_en   = ch_en[in_key];
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = !sel_en || !full[in_key] || out_ready[in_key];
        end
        accept = in_valid && in_ready;
        drain  = full & out_ready;
        load   = 4'b0000;
        if (accept && sel_en) begin
            load[in_key] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 4'b0000;
            drop_err <= 1'b0;
            for (int j = 0; j < 4; j++) begin
                d[j] <= '0;
            end
        end else begin
            drop_err <= accept && !sel_en;
            for (int j = 0; j < 4; j++) begin
                if (load[j]) begin
                    d[j]    <= in_data;
                    full[j] <= 1'b1;
                end else if (drain[j]) begin
                    full[j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        out_valid = full;
        for (int j = 0; j < 4; j++) begin
            out_data[DATA_W*j +: DATA_W] = d[j];
        end
    end

`ifdef STREAM_DEMUX4_CNT_EN
    logic [CNT_W-1:0] cnt [4];

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                cnt[j] <= '0;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (drain[j]) begin
                    cnt[j] <= cnt[j] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            cnt_flat[CNT_W*j +: CNT_W] = cnt[j];
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Directed, table-driven bench for stream_demux4 with hand-computed expectations.
module tb_stream_demux4;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_key;
    logic [DATA_W-1:0]   in_data;
    logic [3:0]          ch_en;
    logic [3:0]          out_valid;
    logic [3:0]          out_ready;
    logic [4*DATA_W-1:0] out_data;
    logic                drop_err;
`ifdef STREAM_DEMUX4_CNT_EN
    logic [4*CNT_W-1:0]  cnt_flat;
`endif

    int vec_count   = 0;
    int miscompares = 0;

    stream_demux4 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_data   (in_data),
        .ch_en     (ch_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_err  (drop_err)
`ifdef STREAM_DEMUX4_CNT_EN
        ,
        .cnt_flat  (cnt_flat)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        in_valid;
        logic [1:0]  in_key;
        logic [7:0]  in_data;
        logic [3:0]  ch_en;
        logic [3:0]  out_ready;
        logic        exp_in_ready;
        logic [3:0]  exp_out_valid;
        logic [31:0] exp_out_data;
        logic        exp_drop_err;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive at negedge, check in_ready before the edge, registered outputs just after it.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        @(negedge clk);
        rst       = v.rst;
        in_valid  = v.in_valid;
        in_key    = v.in_key;
        in_data   = v.in_data;
        ch_en     = v.ch_en;
        out_ready = v.out_ready;
        #1;
        tag = $sformatf("v%0d", idx);
        checkOutput({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, v.exp_in_ready});
        @(posedge clk);
        #1;
        checkOutput({tag, " out_valid"}, {28'd0, out_valid}, {28'd0, v.exp_out_valid});
        checkOutput({tag, " out_data"}, out_data, v.exp_out_data);
        checkOutput({tag, " drop_err"}, {31'd0, drop_err}, {31'd0, v.exp_drop_err});
    endtask

    vec_t vecs[$];

    initial begin
        int delivered;
        rst = 1'b1; in_valid = 1'b0; in_key = 2'd0; in_data = 8'h00;
        ch_en = 4'hF; out_ready = 4'h0;

        //          rst  vld key data   en       ordy     rdy  ov       od            drop
        vecs.push_back('{1, 0, 2'd0, 8'h00, 4'hF,    4'b0000, 0, 4'b0000, 32'h00000000, 0});
        vecs.push_back('{0, 1, 2'd2, 8'hA5, 4'hF,    4'b0000, 1, 4'b0100, 32'h00A50000, 0});
        vecs.push_back('{0, 1, 2'd2, 8'h5A, 4'hF,    4'b0000, 0, 4'b0100, 32'h00A50000, 0});
        vecs.push_back('{0, 1, 2'd2, 8'h5A, 4'hF,    4'b0100, 1, 4'b0100, 32'h005A0000, 0});
        vecs.push_back('{0, 0, 2'd2, 8'h00, 4'hF,    4'b0100, 1, 4'b0000, 32'h005A0000, 0});
        vecs.push_back('{0, 1, 2'd0, 8'h3C, 4'b1110, 4'b0000, 1, 4'b0000, 32'h005A0000, 1});
        vecs.push_back('{0, 1, 2'd0, 8'h3C, 4'b1110, 4'b0000, 1, 4'b0000, 32'h005A0000, 1});
        vecs.push_back('{0, 0, 2'd0, 8'h00, 4'hF,    4'b0000, 1, 4'b0000, 32'h005A0000, 0});
        vecs.push_back('{0, 1, 2'd0, 8'h11, 4'hF,    4'b0000, 1, 4'b0001, 32'h005A0011, 0});
        vecs.push_back('{0, 1, 2'd3, 8'h33, 4'hF,    4'b0000, 1, 4'b1001, 32'h335A0011, 0});
        vecs.push_back('{0, 1, 2'd0, 8'h22, 4'hF,    4'b1000, 0, 4'b0001, 32'h335A0011, 0});
        vecs.push_back('{0, 1, 2'd0, 8'h22, 4'hF,    4'b0001, 1, 4'b0001, 32'h335A0022, 0});
        vecs.push_back('{0, 0, 2'd0, 8'h00, 4'hF,    4'b1110, 0, 4'b0001, 32'h335A0022, 0});
        vecs.push_back('{0, 1, 2'd1, 8'h44, 4'hF,    4'b0000, 1, 4'b0011, 32'h335A4422, 0});
        vecs.push_back('{0, 1, 2'd2, 8'h55, 4'hF,    4'b0000, 1, 4'b0111, 32'h33554422, 0});
        vecs.push_back('{1, 1, 2'd3, 8'h66, 4'hF,    4'b0000, 0, 4'b0000, 32'h00000000, 0});
        vecs.push_back('{0, 0, 2'd3, 8'h00, 4'hF,    4'b0000, 1, 4'b0000, 32'h00000000, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Sustained stream to channel 1 with its consumer always ready.
        $display("[TB] streaming 16 beats to channel 1");
        delivered = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_key = 2'd1; in_data = 8'(i); out_ready = 4'b0010;
            #1;
            checkOutput($sformatf("stream%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("stream%0d out_valid", i), {28'd0, out_valid}, 32'h2);
            checkOutput($sformatf("stream%0d data", i), {24'd0, out_data[15:8]}, i);
            if (out_valid[1] && out_data[15:8] == 8'(i)) delivered++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("stream drained", {28'd0, out_valid}, 32'h0);
        checkOutput("stream delivered", delivered, 32'd16);

`ifdef STREAM_DEMUX4_CNT_EN
        // 257 drains on channel 2 wrap the 8-bit counter to 1.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("cnt after reset", cnt_flat, 32'h0);
        for (int i = 0; i < 257; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_key = 2'd2; in_data = 8'(i); out_ready = 4'b0100;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("cnt wrap", cnt_flat, 32'h00010000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
